// File: rtl/event_encoder83.sv
// Registered 7-to-3 event encoder: synchronizes request lines, captures rising
// edges as pending events and emits one code (bit k -> k+1) per valid/ready transfer.
module event_encoder83 #(
    parameter int SYNC_STAGES = 2,
    parameter bit LOW_FIRST   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] req,
    input  logic       ready,
    input  logic       clr_overrun,
    output logic [2:0] code,
    output logic       valid,
    output logic [6:0] pending,
    output logic       overrun
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t                        state_q, state_d;
    logic [SYNC_STAGES-1:0][6:0]   sync_q;
    logic [6:0]                    prev_q;
    logic [6:0]                    pend_q, pend_d;
    logic [2:0]                    sel_q, sel_d;
    logic [2:0]                    code_q, code_d;
    logic                          valid_q, valid_d;
    logic                          ovr_q, ovr_d;
    logic [6:0]                    rise;
    logic [6:0]                    acc_mask;
    logic                          accept;
    logic                          ovr_set;

    // Scan order makes the last hit the winner: ascending for highest-first,
    // descending for lowest-first.
    function automatic logic [2:0] pick(input logic [6:0] p);
        logic [2:0] k;
        int unsigned j;
        k = '0;
        for (int unsigned i = 0; i < 7; i++) begin
            j = LOW_FIRST ? (6 - i) : i;
            if (p[j]) k = 3'(j);
        end
        return k;
    endfunction

    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign accept   = (state_q == HOLD) && ready;
    assign acc_mask = accept ? (7'd1 << sel_q) : '0;
    assign ovr_set  = |(rise & pend_q & ~acc_mask);

    always_comb begin
        pend_d  = (pend_q & ~acc_mask) | rise;
        ovr_d   = ovr_set ? 1'b1 : (clr_overrun ? 1'b0 : ovr_q);
        state_d = state_q;
        sel_d   = sel_q;
        code_d  = code_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    sel_d   = pick(pend_q);
                    code_d  = pick(pend_q) + 3'd1;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (ready) begin
                    code_d  = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            state_q <= IDLE;
            sel_q   <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], req};
            prev_q  <= sync_q[SYNC_STAGES-1];
            pend_q  <= pend_d;
            state_q <= state_d;
            sel_q   <= sel_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign pending = pend_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_event_encoder83.sv
// Bench for event_encoder83: two instances (2-stage highest-first, 3-stage
// lowest-first) checked every edge against a history-based event model.
module tb_event_encoder83;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] req = 7'h7F;
    logic       ready = 1'b0;
    logic       clr_overrun = 1'b0;

    logic [2:0] code0, code1;
    logic       valid0, valid1;
    logic [6:0] pend0, pend1;
    logic       ovr0, ovr1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    event_encoder83 #(.SYNC_STAGES(2), .LOW_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .clr_overrun(clr_overrun),
        .code(code0), .valid(valid0), .pending(pend0), .overrun(ovr0)
    );

    event_encoder83 #(.SYNC_STAGES(3), .LOW_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req), .ready(ready), .clr_overrun(clr_overrun),
        .code(code1), .valid(valid1), .pending(pend1), .overrun(ovr1)
    );

    // Model: hist[n] is req as sampled n+1 edges ago; a line's synchronized
    // value for depth S is hist[S-1], its previous one hist[S].
    logic [6:0] hist [0:3];
    logic [6:0] m_pend [0:1];
    logic [2:0] m_code [0:1];
    logic       m_valid [0:1];
    logic       m_ovr [0:1];

    function automatic int depth(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    function automatic int choose(input logic [6:0] p, input int lowfirst);
        int v;
        v = int'(p);
        if (lowfirst != 0) return $clog2(v & -v);
        return $clog2(v + 1) - 1;
    endfunction

    task automatic model_edge();
        logic [6:0] rise, amask;
        int s;
        if (!rst_n) begin
            for (int j = 0; j < 4; j++) hist[j] = '0;
            for (int i = 0; i < 2; i++) begin
                m_pend[i] = '0; m_code[i] = '0; m_valid[i] = 1'b0; m_ovr[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                s = depth(i);
                rise  = hist[s-1] & ~hist[s];
                amask = (m_valid[i] && ready) ? 7'(1 << (int'(m_code[i]) - 1)) : 7'h00;
                if ((rise & m_pend[i] & ~amask) != 0) m_ovr[i] = 1'b1;
                else if (clr_overrun)                 m_ovr[i] = 1'b0;
                if (m_valid[i]) begin
                    if (ready) begin
                        m_valid[i] = 1'b0;
                        m_code[i]  = '0;
                    end
                end else if (m_pend[i] != 0) begin
                    m_code[i]  = 3'(choose(m_pend[i], i) + 1);
                    m_valid[i] = 1'b1;
                end
                m_pend[i] = (m_pend[i] & ~amask) | rise;
            end
            for (int j = 3; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = req;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("code0",    8'(code0),  8'(m_code[0]));
        check("valid0",   8'(valid0), 8'(m_valid[0]));
        check("pending0", 8'(pend0),  8'(m_pend[0]));
        check("overrun0", 8'(ovr0),   8'(m_ovr[0]));
        check("code1",    8'(code1),  8'(m_code[1]));
        check("valid1",   8'(valid1), 8'(m_valid[1]));
        check("pending1", 8'(pend1),  8'(m_pend[1]));
        check("overrun1", 8'(ovr1),   8'(m_ovr[1]));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int vcount;

        // Reset held with all lines high, then release.
        ticks(3);
        check("rst_valid", 8'(valid0), 8'h00);
        check("rst_pend",  8'(pend0),  8'h00);
        rst_n = 1'b1;
        ticks(3);
        check("rel_pend_e2", 8'(pend0), 8'h7F);
        tick();
        check("rel_valid_e3", 8'(valid0), 8'h01);
        check("rel_code_e3",  8'(code0),  8'h07);
        ready = 1'b1;
        ticks(20);
        req = '0;
        ticks(8);

        // Single event with ready already high: one valid cycle, code 3.
        req = 7'h04;
        vcount = 0;
        tick(); vcount += int'(valid0);
        tick(); vcount += int'(valid0);
        req = '0;
        for (int k = 0; k < 8; k++) begin
            tick();
            vcount += int'(valid0);
            if (valid0) check("single_code", 8'(code0), 8'h03);
        end
        check("single_vcount", 8'(vcount), 8'h01);

        // Priority and back-pressure.
        ready = 1'b0;
        req = 7'h21;
        ticks(2);
        req = '0;
        ticks(10);
        check("prio_hi_code", 8'(code0), 8'h06);
        check("prio_lo_code", 8'(code1), 8'h01);
        ready = 1'b1;
        ticks(8);

        // Overrun set, set-beats-clear, clear alone.
        ready = 1'b0;
        req = 7'h08; ticks(2);
        req = '0;    ticks(4);
        req = 7'h08; ticks(2);
        req = '0;    ticks(4);
        check("ovr_set", 8'(ovr0), 8'h01);
        req = 7'h08; ticks(2);
        clr_overrun = 1'b1; tick();
        check("ovr_set_wins", 8'(ovr0), 8'h01);
        clr_overrun = 1'b0;
        req = '0;    ticks(4);
        clr_overrun = 1'b1; tick();
        clr_overrun = 1'b0;
        check("ovr_clear", 8'(ovr0), 8'h00);
        ready = 1'b1;
        ticks(8);

        // Re-arm: a new rise on bit 4 lands on the accept edge of code 5.
        ready = 1'b0;
        req = 7'h10; ticks(2);
        req = '0;    ticks(6);
        check("rearm_pre_code", 8'(code0), 8'h05);
        req = 7'h10; ticks(2);
        ready = 1'b1; tick();
        check("rearm_ovr",   8'(ovr0),   8'h00);
        check("rearm_pend",  8'(pend0),  8'h10);
        check("rearm_valid", 8'(valid0), 8'h00);
        ready = 1'b0; tick();
        check("rearm_code", 8'(code0), 8'h05);
        req = '0; ready = 1'b1;
        ticks(10);

        // Reset while holding code 2.
        ready = 1'b0;
        req = 7'h02; ticks(2);
        req = '0;    ticks(6);
        check("hold_code", 8'(code0), 8'h02);
        rst_n = 1'b0; tick();
        check("midrst_valid", 8'(valid0), 8'h00);
        check("midrst_code",  8'(code0),  8'h00);
        check("midrst_pend",  8'(pend0),  8'h00);
        rst_n = 1'b1;
        ticks(10);
        check("post_rst_valid", 8'(valid0), 8'h00);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(7) == 0) req = req ^ 7'(1 << $urandom_range(6));
            ready       = ($urandom_range(2) != 0);
            clr_overrun = ($urandom_range(15) == 0);
            rst_n       = ($urandom_range(299) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
